alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that produces the ALU's input interface: ALUOp, in1, in2.
- Decodes one 32-bit MIPS-style instruction plus register-file read values into registered, ALU-ready operands and the 5-bit ALU opcode.
- Adds the destination register and write enable.
- Sits between decode/register read and execute; valid/ready handshake on both sides with synchronous flush.

Parameters:
- DW, 32, operand/data width (only 32 supported)
- RW, 5, register index width

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream beat valid
- in_ready  output  1  stage can accept a beat this cycle
- instr  input  32  instruction word
- rs_val  input  32  register-file value of instr[25:21]
- rt_val  input  32  register-file value of instr[20:16]
- flush  input  1  synchronous kill of held and incoming beat
- out_valid  output  1  registered beat valid toward execute
- out_ready  input  1  execute accepts beat
- ALUOp  output  5  ALU operation code
- in1  output  32  ALU operand 1 (shift amount for shifts)
- in2  output  32  ALU operand 2
- wr_reg  output  5  destination register index
- wr_en  output  1  beat writes a register
- illegal  output  1  beat carries an undecodable instruction (sticky per beat)

Behaviour:
- Reset (rst_n low, async): out_valid=0, ALUOp=5'b00001, in1=0, in2=0, wr_reg=0, wr_en=0, illegal=0. Deassertion takes effect on the next clk edge.
- in_ready = !out_valid || out_ready (combinational). Beat accepted when in_valid && in_ready; outputs register it next edge. Latency 1 cycle; throughput 1 beat/cycle.
- Hold: out_valid && !out_ready -> all outputs stable, in_ready=0.
- Drain: out_ready && !accept -> out_valid clears. Data outputs may hold stale values.
- Flush highest priority: out_valid<=0 next edge and any same-cycle accepted beat is discarded. in_ready is unaffected by flush.
- ALUOp codes: 00000 add, 00001 zero, 00010 sub, 00011 and, 00100 or, 00101 xor, 00110 nor, 00111 sll (in2<<in1), 01000 srl, 01001 sra, 01010 sltu, 01011 slt.
- sext = sign-extend imm[15:0]; zext = zero-extend.
- opcode 000000, in1=rs_val, in2=rt_val, wr_reg=rd, wr_en=1, by funct:
  - 100000/100001 add
  - 100010/100011 sub
  - 100100 and, 100101 or, 100110 xor, 100111 nor
  - 101010 slt, 101011 sltu
- Immediate shifts: funct 000000 sll, 000010 srl, 000011 sra; in1={27'b0,shamt}, in2=rt_val.
- Variable shifts: funct 000100/000110/000111 = sll/srl/sra; in1={27'b0,rs_val[4:0]}, in2=rt_val.
- I-type, in1=rs_val, wr_reg=rt, wr_en=1:
  - 001000/001001 add, in2=sext
  - 001010 slt, in2=sext
  - 001011 sltu, in2=sext
  - 001100 and, 001101 or, 001110 xor, in2=zext
- lui 001111: ALUOp sll, in1=16, in2=zext, wr_reg=rt, wr_en=1.
- lw 100011: add, in2=sext, wr_reg=rt, wr_en=1.
- sw 101011: add, in2=sext, wr_en=0, wr_reg=0.
- beq 000100 / bne 000101: sub, in1=rs_val, in2=rt_val, wr_en=0, wr_reg=0.
- Destination register 0: wr_en forced 0 whenever the destination is register 0.
- Anything else: ALUOp=00001, in1=in2=0, wr_en=0, illegal=1. illegal=0 on every legal beat.
- Reset mid-hold: the beat is lost; no replay.

Test Plan:
- Reset then release, in_valid=0 -> out_valid=0, ALUOp=00001, in1=in2=0, in_ready=1.
- addi $3,$2,-4 (0x2043FFFC), rs_val=10 -> next cycle out_valid=1, ALUOp=00000, in1=10, in2=0xFFFFFFFC, wr_reg=3, wr_en=1.
- Shifts:
  - sra $5,$6,4 (0x00062903), rt_val=0x80000000 -> ALUOp=01001, in1=4, in2=0x80000000, wr_reg=5.
  - lui $1,0x1234 -> ALUOp=00111, in1=16, in2=0x00001234.
- Backpressure: out_ready=0 for 3 cycles with a held beat and in_valid=1 -> in_ready=0, outputs stable. Then out_ready=1 -> next beat accepted, no loss or duplicate over a 10-beat stream.
- Flush and illegal:
  - flush=1 while holding a beat and accepting a new one -> out_valid=0 next cycle; neither beat ever appears.
  - Opcode 0x3F -> illegal=1, ALUOp=00001, wr_en=0.
- Destination register 0 and stores:
  - add $0,$1,$2 -> wr_en=0.
  - sw -> wr_en=0, ALUOp=00000, in2=sext offset.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// ID/EX issue register for the ALU. Decodes one MIPS-style instruction word
// together with its two register-file read values into ALU-ready operands,
// the 5-bit ALU opcode, the destination register and its write enable, then
// registers them toward execute behind a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready upstream handshake (in_ready = !out_valid || out_ready)
//   instr             instruction word
//   rs_val, rt_val    register-file values of instr[25:21] / instr[20:16]
//   flush             synchronous kill of the held and any incoming beat
//   out_valid/out_ready downstream handshake toward execute
//   ALUOp, in1, in2   ALU opcode and operands (in1 = shift amount for shifts)
//   wr_reg, wr_en     destination register index and write enable
//   illegal           beat carries an undecodable instruction
// ---------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  input  logic [DW-1:0] rs_val,
  input  logic [DW-1:0] rt_val,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4:0]    ALUOp,
  output logic [DW-1:0] in1,
  output logic [DW-1:0] in2,
  output logic [RW-1:0] wr_reg,
  output logic          wr_en,
  output logic          illegal
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_ZERO = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_XOR  = 5'b00101;
  localparam logic [4:0] OP_NOR  = 5'b00110;
  localparam logic [4:0] OP_SLL  = 5'b00111;
  localparam logic [4:0] OP_SRL  = 5'b01000;
  localparam logic [4:0] OP_SRA  = 5'b01001;
  localparam logic [4:0] OP_SLTU = 5'b01010;
  localparam logic [4:0] OP_SLT  = 5'b01011;

  function automatic logic signed [DW-1:0] sext16(input logic [15:0] imm);
    return {{(DW-16){imm[15]}}, imm};
  endfunction

  function automatic logic [DW-1:0] zext16(input logic [15:0] imm);
    return {{(DW-16){1'b0}}, imm};
  endfunction

  function automatic logic [DW-1:0] zext5(input logic [4:0] amt);
    return {{(DW-5){1'b0}}, amt};
  endfunction

  // ---- p0: combinational decode of the incoming beat ----
  logic [5:0]           opcode_p0;
  logic [5:0]           funct_p0;
  logic [RW-1:0]        rt_idx_p0;
  logic [RW-1:0]        rd_idx_p0;
  logic [4:0]           shamt_p0;
  logic signed [DW-1:0] imm_s_p0;
  logic [DW-1:0]        imm_z_p0;
  logic                 accept_p0;

  logic [4:0]           aluop_p0;
  logic [DW-1:0]        in1_p0;
  logic [DW-1:0]        in2_p0;
  logic [RW-1:0]        dest_p0;
  logic                 has_dest_p0;
  logic                 legal_p0;
  logic [RW-1:0]        wr_reg_p0;
  logic                 wr_en_p0;

  // Source register index is not needed: its value arrives on rs_val.
  logic unused_rs_idx;
  assign unused_rs_idx = ^instr[25:21];

  assign opcode_p0 = instr[31:26];
  assign funct_p0  = instr[5:0];
  assign rt_idx_p0 = instr[20:16];
  assign rd_idx_p0 = instr[15:11];
  assign shamt_p0  = instr[10:6];
  assign imm_s_p0  = sext16(instr[15:0]);
  assign imm_z_p0  = zext16(instr[15:0]);

  assign in_ready  = !out_valid || out_ready;
  assign accept_p0 = in_valid && in_ready;

  always_comb begin
    aluop_p0    = OP_ZERO;
    in1_p0      = '0;
    in2_p0      = '0;
    dest_p0     = '0;
    has_dest_p0 = 1'b0;
    legal_p0    = 1'b1;
    case (opcode_p0)
      6'b000000: begin
        in1_p0      = rs_val;
        in2_p0      = rt_val;
        dest_p0     = rd_idx_p0;
        has_dest_p0 = 1'b1;
        case (funct_p0)
          6'b100000, 6'b100001: aluop_p0 = OP_ADD;
          6'b100010, 6'b100011: aluop_p0 = OP_SUB;
          6'b100100: aluop_p0 = OP_AND;
          6'b100101: aluop_p0 = OP_OR;
          6'b100110: aluop_p0 = OP_XOR;
          6'b100111: aluop_p0 = OP_NOR;
          6'b101010: aluop_p0 = OP_SLT;
          6'b101011: aluop_p0 = OP_SLTU;
          6'b000000: begin aluop_p0 = OP_SLL; in1_p0 = zext5(shamt_p0); end
          6'b000010: begin aluop_p0 = OP_SRL; in1_p0 = zext5(shamt_p0); end
          6'b000011: begin aluop_p0 = OP_SRA; in1_p0 = zext5(shamt_p0); end
          6'b000100: begin aluop_p0 = OP_SLL; in1_p0 = zext5(rs_val[4:0]); end
          6'b000110: begin aluop_p0 = OP_SRL; in1_p0 = zext5(rs_val[4:0]); end
          6'b000111: begin aluop_p0 = OP_SRA; in1_p0 = zext5(rs_val[4:0]); end
          default:   legal_p0 = 1'b0;
        endcase
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110: begin
        in1_p0      = rs_val;
        dest_p0     = rt_idx_p0;
        has_dest_p0 = 1'b1;
        // Arithmetic/compare immediates sign-extend; logical ones zero-extend.
        in2_p0      = opcode_p0[2] ? imm_z_p0 : imm_s_p0;
        case (opcode_p0)
          6'b001010: aluop_p0 = OP_SLT;
          6'b001011: aluop_p0 = OP_SLTU;
          6'b001100: aluop_p0 = OP_AND;
          6'b001101: aluop_p0 = OP_OR;
          6'b001110: aluop_p0 = OP_XOR;
          default:   aluop_p0 = OP_ADD;
        endcase
      end
      6'b001111: begin
        // lui is carried out by the ALU as imm << 16.
        aluop_p0    = OP_SLL;
        in1_p0      = DW'(16);
        in2_p0      = imm_z_p0;
        dest_p0     = rt_idx_p0;
        has_dest_p0 = 1'b1;
      end
      6'b100011: begin
        aluop_p0    = OP_ADD;
        in1_p0      = rs_val;
        in2_p0      = imm_s_p0;
        dest_p0     = rt_idx_p0;
        has_dest_p0 = 1'b1;
      end
      6'b101011: begin
        aluop_p0 = OP_ADD;
        in1_p0   = rs_val;
        in2_p0   = imm_s_p0;
      end
      6'b000100, 6'b000101: begin
        aluop_p0 = OP_SUB;
        in1_p0   = rs_val;
        in2_p0   = rt_val;
      end
      default: legal_p0 = 1'b0;
    endcase
    if (!legal_p0) begin
      aluop_p0    = OP_ZERO;
      in1_p0      = '0;
      in2_p0      = '0;
      dest_p0     = '0;
      has_dest_p0 = 1'b0;
    end
  end

  // Writes to register 0 are dropped at issue so execute never sees them.
  assign wr_reg_p0 = has_dest_p0 ? dest_p0 : '0;
  assign wr_en_p0  = has_dest_p0 && (dest_p0 != '0);

  // ---- p1: issue register toward execute ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ALUOp     <= OP_ZERO;
      in1       <= '0;
      in2       <= '0;
      wr_reg    <= '0;
      wr_en     <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (accept_p0) out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      // Data only moves on a surviving accept, so a held beat stays stable.
      if (accept_p0 && !flush) begin
        ALUOp   <= aluop_p0;
        in1     <= in1_p0;
        in2     <= in2_p0;
        wr_reg  <= wr_reg_p0;
        wr_en   <= wr_en_p0;
        illegal <= !legal_p0;
      end
    end
  end

endmodule
